mips_lsu: RTL and testbench
===========================

MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 Parameter: ADDR_W, 12, byte-address width shared with data RAM.
REQ-002 Port: clk  input  1  single clock; all state changes on posedge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  CPU load/store request present.
REQ-005 Port: req_ready  output  1  LSU can accept request.
REQ-006 Port: req_we  input  1  1=store, 0=load.
REQ-007 Port: req_op  input  3  [1:0] size: 00=byte, 01=half, 10=word, 11=reserved; [2]=unsigned load (lbu/lhu), ignored for stores.
REQ-008 Port: req_addr  input  ADDR_W  byte address.
REQ-009 Port: req_wdata  input  32  store data, right-justified.
REQ-010 Port: rsp_valid  output  1  response available.
REQ-011 Port: rsp_ready  input  1  CPU consumes response.
REQ-012 Port: rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 Port: rsp_err  output  1  request rejected, no RAM access made.
REQ-014 Port: ram_addr / ram_din / ram_wen / ram_mode  output  ADDR_W/32/1/2  drive the data RAM Addr_i/D_in/W_en/Mode.
REQ-015 Port: ram_dout  input  32  RAM D_out, updated on RAM negedge, zero-extended for byte/half.
REQ-016 Port: err_cnt  output  8  saturating count of rejected requests.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RESP; req_ready SHALL be 1 only in IDLE with rst_n high.
REQ-018 Handshake SHALL be req_valid&&req_ready at posedge; request fields captured into registers; IDLE->ISSUE, or IDLE->RESP when rejected.
REQ-019 In ISSUE, ram_addr=captured addr, ram_din=captured wdata, ram_mode= 00 word / 10 half / 01 byte, ram_wen=captured we; RAM acts on the intervening negedge.
REQ-020 ram_wen SHALL be 0 in every state other than ISSUE; ram_addr/ram_din/ram_mode hold last value outside ISSUE.
REQ-021 At posedge leaving ISSUE, LSU SHALL go to RESP and register rsp_rdata from ram_dout for loads: byte sign-extends bit 7 and half sign-extends bit 15 unless req_op[2]=1 (zero-extend); word passes through.
REQ-022 Latency SHALL be: rsp_valid high exactly 2 posedges after acceptance edge for accepted accesses, 1 posedge for rejected ones.
REQ-023 In RESP, rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready at posedge, then ->IDLE; next request not accepted on that same edge.
REQ-024 req_op[1:0]=11 SHALL always be rejected: rsp_err=1, rsp_rdata=0, no RAM cycle.
REQ-025 err_cnt SHALL increment by 1 on each entry into RESP with rsp_err=1, saturating at 255.
REQ-026 Back-to-back: minimum request spacing SHALL be 3 cycles (IDLE, ISSUE, RESP with rsp_ready=1).

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_wen=0, ram_addr=0, ram_din=0, ram_mode=00, err_cnt=0.
REQ-028 Reset asserted during ISSUE before the negedge SHALL suppress the RAM write; pending response SHALL be discarded.
REQ-029 First request acceptable on first posedge after rst_n release.

Configuration
REQ-030 Macro MIPS_LSU_ALIGN_CHK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL be rejected (REQ-024 behaviour, err_cnt counts).
REQ-031 Macro MIPS_LSU_ALIGN_CHK_EN undefined: misaligned addresses SHALL pass to RAM unchanged (RAM truncates), rsp_err only for reserved ops.

Verification
REQ-032 sw addr 0x010 data 0xA1B2C3D4, then lw 0x010 -> rsp_rdata=0xA1B2C3D4, rsp_err=0, rsp_valid 2 edges after accept.
REQ-033 sb addr 0x021 data 0x000000F0, then lb 0x021 -> 0xFFFFFFF0; lbu 0x021 -> 0x000000F0.
REQ-034 sh addr 0x032 data 0x8001, then lh 0x032 -> 0xFFFF8001; lhu -> 0x00008001; ram_mode=10 in ISSUE.
REQ-035 With MIPS_LSU_ALIGN_CHK_EN, lw 0x013 -> rsp_err=1, rsp_rdata=0, ram_wen never 1, err_cnt=1; without macro -> rsp_err=0, data from 0x010.
REQ-036 sw accepted then rst_n low before negedge -> ram_wen=0, later lw returns prior contents, all outputs at reset values.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0; 256 reserved-op requests -> err_cnt=255.

Source files
------------

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - MIPS load/store unit between a CPU request port and a negedge-clocked data RAM
// Optional feature macro: MIPS_LSU_ALIGN_CHK_EN (reject misaligned half/word accesses).
module mips_lsu #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_wen,
  output logic [1:0]        ram_mode,
  input  logic [31:0]       ram_dout,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q;
  logic                we_q;
  logic [2:0]          op_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [31:0]         ram_din_q;
  logic                ram_wen_q;
  logic [1:0]          ram_mode_q;
  logic [7:0]          err_cnt_q;

  logic                req_fire;
  logic                reject_d;
  logic [1:0]          mode_d;
  logic [31:0]         load_d;

  // Ready only while idle and out of reset; reset drops it immediately.
  assign req_ready = (state_q == IDLE) && rst_n;
  assign req_fire  = req_valid && req_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_wen   = ram_wen_q;
  assign ram_mode  = ram_mode_q;
  assign err_cnt   = err_cnt_q;

  // Map the CPU size code onto the RAM mode encoding (word=00, half=10, byte=01).
  always_comb begin
    mode_d = 2'b00;
    case (req_op[1:0])
      2'b00:   mode_d = 2'b01;
      2'b01:   mode_d = 2'b10;
      default: mode_d = 2'b00;
    endcase
  end

  // Decide whether the incoming request is refused without touching the RAM.
  always_comb begin
    reject_d = (req_op[1:0] == 2'b11);
`ifdef MIPS_LSU_ALIGN_CHK_EN
    if ((req_op[1:0] == 2'b01) && req_addr[0])
      reject_d = 1'b1;
    if ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      reject_d = 1'b1;
`endif
  end

  // Extend RAM read data (already zero-extended by the RAM) according to the captured load op.
  always_comb begin
    load_d = ram_dout;
    case (op_q[1:0])
      2'b00:   load_d = op_q[2] ? {24'h0, ram_dout[7:0]}
                                : {{24{ram_dout[7]}}, ram_dout[7:0]};
      2'b01:   load_d = op_q[2] ? {16'h0, ram_dout[15:0]}
                                : {{16{ram_dout[15]}}, ram_dout[15:0]};
      default: load_d = ram_dout;
    endcase
  end

  // Request FSM with registered RAM and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      op_q        <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= 32'h0;
      ram_wen_q   <= 1'b0;
      ram_mode_q  <= 2'b00;
      err_cnt_q   <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            we_q <= req_we;
            op_q <= req_op;
            if (reject_d) begin
              // Refused requests skip the RAM and answer on the next cycle.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
              if (err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'h01;
            end else begin
              // RAM port is driven for the whole ISSUE cycle; the RAM acts on its negedge.
              state_q    <= ISSUE;
              ram_addr_q <= req_addr;
              ram_din_q  <= req_wdata;
              ram_mode_q <= mode_d;
              ram_wen_q  <= req_we;
            end
          end
        end
        ISSUE: begin
          state_q     <= RESP;
          ram_wen_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? 32'h0 : load_d;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          ram_wen_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// tb/tb_mips_lsu.sv - directed self-checking bench for mips_lsu with a behavioural negedge data RAM
module tb_mips_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_wen;
  logic [1:0]  ram_mode;
  logic [31:0] ram_dout;
  logic [7:0]  err_cnt;

  int total;
  int bad;

  logic [7:0] mem [0:4095];

  mips_lsu #(.ADDR_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_wen   (ram_wen),
    .ram_mode  (ram_mode),
    .ram_dout  (ram_dout),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian RAM: truncates misaligned addresses, acts on negedge, zero-extends reads.
  always @(negedge clk) begin
    int a;
    a = int'(ram_addr);
    if (ram_mode == 2'b00) a = a & ~3;
    else if (ram_mode == 2'b10) a = a & ~1;
    if (ram_wen) begin
      mem[a] <= ram_din[7:0];
      if (ram_mode != 2'b01) mem[a+1] <= ram_din[15:8];
      if (ram_mode == 2'b00) begin
        mem[a+2] <= ram_din[23:16];
        mem[a+3] <= ram_din[31:24];
      end
    end
    if (ram_mode == 2'b00)      ram_dout <= {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    else if (ram_mode == 2'b10) ram_dout <= {16'h0, mem[a+1], mem[a]};
    else                        ram_dout <= {24'h0, mem[a]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":req_ready"}, req_ready, 0);
    chk({tag, ":rsp_valid"}, rsp_valid, 0);
    chk({tag, ":rsp_err"},   rsp_err,   0);
    chk({tag, ":rsp_rdata"}, rsp_rdata, 0);
    chk({tag, ":ram_wen"},   ram_wen,   0);
    chk({tag, ":ram_addr"},  ram_addr,  0);
    chk({tag, ":ram_din"},   ram_din,   0);
    chk({tag, ":ram_mode"},  ram_mode,  0);
    chk({tag, ":err_cnt"},   err_cnt,   0);
  endtask

  // One complete request/response with latency, RAM-port and response checks.
  task automatic do_req(input string tag, input logic we, input logic [2:0] op,
                        input logic [11:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
    int n;
    logic [1:0] em;
    em = (op[1:0] == 2'b00) ? 2'b01 : (op[1:0] == 2'b01) ? 2'b10 : 2'b00;
    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (exp_err) begin
      chk({tag, ":rej_valid_1edge"}, rsp_valid, 1);
      chk({tag, ":rej_no_wen"}, ram_wen, 0);
    end else begin
      chk({tag, ":valid_early"}, rsp_valid, 0);
      chk({tag, ":issue_wen"}, ram_wen, we);
      chk({tag, ":issue_mode"}, ram_mode, em);
      chk({tag, ":issue_addr"}, ram_addr, addr);
      if (we) chk({tag, ":issue_din"}, ram_din, wd);
      @(posedge clk); #1;
      chk({tag, ":valid_2edge"}, rsp_valid, 1);
      chk({tag, ":resp_wen"}, ram_wen, 0);
    end
    chk({tag, ":err"}, rsp_err, exp_err);
    chk({tag, ":rdata"}, rsp_rdata, exp_rd);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ":done_valid"}, rsp_valid, 0);
    chk({tag, ":done_ready"}, req_ready, 1);
  endtask

  logic exp_align_err;
  logic [31:0] exp_mis_rd;
  logic [7:0]  exp_cnt;

  initial begin
    total = 0;
    bad   = 0;
`ifdef MIPS_LSU_ALIGN_CHK_EN
    exp_align_err = 1'b1;
    exp_mis_rd    = 32'h0;
`else
    exp_align_err = 1'b0;
    exp_mis_rd    = 32'hA1B2C3D4;
`endif
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b0;
    req_addr = 12'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", req_ready, 1);

    // Word store/load round trip
    do_req("sw010", 1'b1, 3'b010, 12'h010, 32'hA1B2C3D4, 1'b0, 32'h0);
    do_req("lw010", 1'b0, 3'b010, 12'h010, 32'h0, 1'b0, 32'hA1B2C3D4);

    // Byte store, signed and unsigned byte loads
    do_req("sb021",  1'b1, 3'b000, 12'h021, 32'h000000F0, 1'b0, 32'h0);
    do_req("lb021",  1'b0, 3'b000, 12'h021, 32'h0, 1'b0, 32'hFFFFFFF0);
    do_req("lbu021", 1'b0, 3'b100, 12'h021, 32'h0, 1'b0, 32'h000000F0);
    do_req("sb022",  1'b1, 3'b000, 12'h022, 32'h12345675, 1'b0, 32'h0);
    do_req("lb022",  1'b0, 3'b000, 12'h022, 32'h0, 1'b0, 32'h00000075);

    // Half store, signed and unsigned half loads
    do_req("sh032",  1'b1, 3'b001, 12'h032, 32'h00008001, 1'b0, 32'h0);
    do_req("lh032",  1'b0, 3'b001, 12'h032, 32'h0, 1'b0, 32'hFFFF8001);
    do_req("lhu032", 1'b0, 3'b101, 12'h032, 32'h0, 1'b0, 32'h00008001);

    // Reset during ISSUE suppresses the store
    do_req("sw040", 1'b1, 3'b010, 12'h040, 32'h11223344, 1'b0, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010;
    req_addr = 12'h040; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_issue_wen", ram_wen, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    do_req("lw040", 1'b0, 3'b010, 12'h040, 32'h0, 1'b0, 32'h11223344);

    // Misaligned word load
    do_req("lw013", 1'b0, 3'b010, 12'h013, 32'h0, exp_align_err, exp_mis_rd);
    exp_cnt = exp_align_err ? 8'd1 : 8'd0;
    chk("err_cnt_align", err_cnt, exp_cnt);

    // Response stall: outputs hold while rsp_ready is low
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 12'h010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 32'hA1B2C3D4);
      chk("stall_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    // Request presented on the consuming edge must wait one cycle
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("handoff_valid", rsp_valid, 0);
    chk("handoff_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("handoff_accept", req_ready, 0);
    chk("handoff_early", rsp_valid, 0);
    @(posedge clk); #1;
    chk("handoff_valid2", rsp_valid, 1);
    chk("handoff_rdata", rsp_rdata, 32'hA1B2C3D4);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reserved ops always rejected; counter saturates
    for (int i = 0; i < 255; i++) begin
      do_req("rsvd", 1'($urandom_range(0, 1)), (i % 2 == 0) ? 3'b011 : 3'b111,
             12'($urandom_range(0, 4095)), $urandom, 1'b1, 32'h0);
      if (i == 9) begin
        exp_cnt = exp_align_err ? 8'd11 : 8'd10;
        chk("err_cnt_10", err_cnt, exp_cnt);
      end
    end
    chk("err_cnt_255", err_cnt, 8'd255);
    do_req("rsvd_sat", 1'b1, 3'b011, 12'h010, 32'hFFFFFFFF, 1'b1, 32'h0);
    chk("err_cnt_sat", err_cnt, 8'd255);
    do_req("lw010_end", 1'b0, 3'b010, 12'h010, 32'h0, 1'b0, 32'hA1B2C3D4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
